// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants for the BCD digit chain: digit width and 7-segment codes.
package bcd_display_scanner_pkg;

    localparam int unsigned BCD_W = 4;

    // Segment order {g,f,e,d,c,b,a}, active-high (1 = segment lit)
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_display_scanner_bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
    import bcd_display_scanner_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [6:0]       seg_c
);

    // Lookup of the active-high segment pattern
    always_comb begin
        seg_c = SEG_DASH;
        case (digit)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner with per-frame snapshot, leading-zero
// blanking, decimal points and per-digit blink.
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter int unsigned GUARD_CYCLES   = 16,
    parameter int unsigned BLINK_FRAMES   = 64,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BCD_W*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]         dp_mask,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    input  logic                          blank_lz,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned DIG_W = BCD_W * NUM_DIGITS;

    localparam logic [6:0]            SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_IDLE  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? '1 : '0;

    logic [CNT_W-1:0]      slot_cnt,  slot_nxt;
    logic [IDX_W-1:0]      idx,       idx_nxt;
    logic [DIG_W-1:0]      snap_dig,  snap_dig_nxt;
    logic [NUM_DIGITS-1:0] snap_dp,   snap_dp_nxt;
    logic [NUM_DIGITS-1:0] snap_blk,  snap_blk_nxt;
    logic [BLK_W-1:0]      blink_cnt, blink_cnt_nxt;
    logic                  phase,     phase_nxt;

    logic                  slot_last, idx_last, frame_edge;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_run;
    logic [BCD_W-1:0]      cur_digit;
    logic [6:0]            dec_seg_c;
    logic                  blink_off, blanked;
    logic [6:0]            seg_hi;
    logic                  dp_hi;
    logic [NUM_DIGITS-1:0] an_hi;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] an_d;

    bcd_to_7seg u_dec (
        .digit (cur_digit),
        .seg_c (dec_seg_c)
    );

    // Next-state of the scan counters, snapshot and blink timer
    always_comb begin
        slot_last     = (slot_cnt == CNT_W'(REFRESH_DIV - 1));
        idx_last      = (idx == IDX_W'(NUM_DIGITS - 1));
        frame_edge    = slot_last && idx_last;
        slot_nxt      = slot_cnt + CNT_W'(1);
        idx_nxt       = idx;
        snap_dig_nxt  = snap_dig;
        snap_dp_nxt   = snap_dp;
        snap_blk_nxt  = snap_blk;
        blink_cnt_nxt = blink_cnt;
        phase_nxt     = phase;
        if (slot_last) begin
            slot_nxt = '0;
            idx_nxt  = idx_last ? '0 : idx + IDX_W'(1);
        end
        if (frame_edge) begin
            snap_dig_nxt = digits;
            snap_dp_nxt  = dp_mask;
            snap_blk_nxt = blink_mask;
            if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_nxt = '0;
                phase_nxt     = ~phase;
            end else begin
                blink_cnt_nxt = blink_cnt + BLK_W'(1);
            end
        end
    end

    // Output pattern for the upcoming cycle, derived from next-state values
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run    = zero_run && (snap_dig_nxt[BCD_W*k +: BCD_W] == '0);
            lz_blank[k] = zero_run && (k != 0);
        end
        cur_digit = snap_dig_nxt[BCD_W*32'(idx_nxt) +: BCD_W];
        blink_off = phase_nxt && snap_blk_nxt[idx_nxt];
        blanked   = blank_lz && lz_blank[idx_nxt];
        seg_hi    = (blink_off || blanked) ? SEG_OFF : dec_seg_c;
        dp_hi     = snap_dp_nxt[idx_nxt] && !blink_off;
        an_hi     = (slot_nxt >= CNT_W'(GUARD_CYCLES)) ? (NUM_DIGITS'(1) << idx_nxt) : '0;
        seg_d     = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        dp_d      = SEG_ACTIVE_LOW ? ~dp_hi  : dp_hi;
        an_d      = AN_ACTIVE_LOW  ? ~an_hi  : an_hi;
    end

    // Scan counters, frame snapshot and blink state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt  <= '0;
            idx       <= '0;
            snap_dig  <= '0;
            snap_dp   <= '0;
            snap_blk  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            slot_cnt  <= slot_nxt;
            idx       <= idx_nxt;
            snap_dig  <= snap_dig_nxt;
            snap_dp   <= snap_dp_nxt;
            snap_blk  <= snap_blk_nxt;
            blink_cnt <= blink_cnt_nxt;
            phase     <= phase_nxt;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg        <= SEG_IDLE;
            dp         <= DP_IDLE;
            an         <= AN_IDLE;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_d;
            dp         <= dp_d;
            an         <= an_d;
            frame_tick <= frame_edge;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: a cycle-indexed reference model
// pushes expected outputs, a negedge monitor pops and compares.
module tb_bcd_display_scanner;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 4;
    localparam int unsigned GC = 1;
    localparam int unsigned BF = 2;
    localparam int unsigned FRAME = ND * RD;

    localparam logic [6:0] DEC_TAB [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   digits;
    logic [3:0]    dp_mask;
    logic [3:0]    blink_mask;
    logic          blank_lz;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_tick;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];

    bcd_display_scanner #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (RD),
        .GUARD_CYCLES   (GC),
        .BLINK_FRAMES   (BF),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: state after k clock edges since reset release
    int unsigned k_edges = 0;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic [3:0]  m_blk;

    always @(posedge clk) begin
        int unsigned p, slot, c, f;
        logic [3:0]  d;
        logic        hi_zero, blanked, off, phase;
        exp_t        e;
        if (!reset) begin
            k_edges = 0;
            m_dig   = '0;
            m_dp    = '0;
            m_blk   = '0;
        end else begin
            k_edges = k_edges + 1;
            p    = k_edges % FRAME;
            slot = p / RD;
            c    = p % RD;
            f    = k_edges / FRAME;
            if (p == 0) begin
                m_dig = digits;
                m_dp  = dp_mask;
                m_blk = blink_mask;
            end
            phase   = ((f / BF) % 2) == 1;
            d       = 4'(m_dig >> (4 * slot));
            hi_zero = (m_dig >> (4 * slot)) == 16'h0;
            blanked = blank_lz && (slot != 0) && hi_zero;
            off     = phase && m_blk[slot];
            e.seg   = ~((blanked || off) ? 7'h00 : DEC_TAB[d]);
            e.dp    = ~(m_dp[slot] && !off);
            e.an    = (c >= GC) ? ~(4'b0001 << slot) : 4'hF;
            e.tick  = (p == 0);
            exp_q.push_back(e);
        end
    end

    // Monitor: compare every presented output cycle against the model
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_tick !== e.tick) begin
                failures++;
                $display("FAIL scan k=%0d: got an=%b seg=%h dp=%b tick=%b, want an=%b seg=%h dp=%b tick=%b",
                         k_edges, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.tick);
            end
        end
    end

    task automatic check_idle(input string name);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL %s: got an=%b seg=%h dp=%b tick=%b, want an=1111 seg=7f dp=1 tick=0",
                     name, an, seg, dp, frame_tick);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic [15:0] dg, input logic [3:0] dpm,
                          input logic [3:0] bm, input logic lz);
        digits     = dg;
        dp_mask    = dpm;
        blink_mask = bm;
        blank_lz   = lz;
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v = '0;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1)
                v[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        bit found;
        reset = 1'b0;
        set_in(16'h0000, 4'h0, 4'h0, 1'b1);

        // Reset held: outputs idle
        #23;
        check_idle("reset_hold");
        run(3);
        check_idle("reset_hold2");
        reset = 1'b1;

        // First frame shows the zero snapshot, then directed patterns
        run(FRAME);
        set_in(16'h1234, 4'h0, 4'h0, 1'b0);
        run(3 * FRAME);
        set_in(16'h0050, 4'b0100, 4'h0, 1'b1);
        run(2 * FRAME + 3);

        // Mid-frame change: 0009 then 0010 halfway through a frame
        set_in(16'h0009, 4'h0, 4'h0, 1'b1);
        run(FRAME + FRAME / 2);
        digits = 16'h0010;
        run(2 * FRAME);

        // Blink: digits 0 and 1 toggle every two frames
        set_in(16'h1259, 4'b0011, 4'b0011, 1'b0);
        run(9 * FRAME);

        // Non-BCD digit, then reset asserted mid-slot 2
        set_in(16'h00A0, 4'h0, 4'h0, 1'b1);
        run(2 * FRAME);
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            if (((k_edges % FRAME) / RD) == 2 && (k_edges % RD) == 2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL slot2_search: got no slot-2 position within %0d cycles, want one", 2 * FRAME);
        end
        #2;
        reset = 1'b0;
        #1;
        check_idle("async_reset");
        run(2);
        check_idle("reset_after");
        reset = 1'b1;
        run(2 * FRAME);

        // Randomized inputs changed at random points in the frame
        for (int n = 0; n < 60; n++) begin
            set_in(rand_digits(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)));
            run($urandom_range(1, 2 * FRAME));
        end
        run(FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Reader side of the BCD digit counter chain. Takes the packed BCD digits produced by the cascaded digit counters and drives a time-multiplexed common-anode 7-segment display.
- One digit is lit per scan slot. Digits are snapshotted once per frame, so a display frame never mixes pre- and post-carry values.
- Also provides leading-zero blanking, per-digit decimal points and per-digit blink, used when setting the clock.

Parameters:
- NUM_DIGITS, 4, number of BCD digits and anodes (2..8).
- REFRESH_DIV, 100000, clk cycles per digit slot (>= GUARD_CYCLES+2).
- GUARD_CYCLES, 16, cycles at the start of each slot with all anodes off (anti-ghosting); 0 is legal.
- BLINK_FRAMES, 64, frames per blink half-period (>= 1).
- SEG_ACTIVE_LOW, 1, invert seg and dp outputs when 1.
- AN_ACTIVE_LOW, 1, invert an outputs when 1.

Ports:
- clk  in  1  system clock, rising edge only.
- reset  in  1  asynchronous, active-low reset.
- digits  in  4*NUM_DIGITS  packed BCD; digit 0 = bits [3:0] = least significant, rightmost.
- dp_mask  in  NUM_DIGITS  decimal point request per digit.
- blink_mask  in  NUM_DIGITS  digits to blink.
- blank_lz  in  1  enable leading-zero blanking.
- seg  out  7  {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.
- an  out  NUM_DIGITS  anode enables, one-hot when active.
- frame_tick  out  1  one-cycle pulse at each frame boundary (snapshot taken).

Behaviour:
- Reset (reset=0, async):
  - Slot counter = 0, digit index = 0, snapshot registers = 0, blink counter = 0, blink phase = 0 (visible).
  - an = all inactive; seg and dp = off (polarity per parameters); frame_tick = 0.
- Slot counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index advances 0→1→…→NUM_DIGITS-1→0.
- Frame boundary = slot wrap with index NUM_DIGITS-1.
  - Same edge: digits, dp_mask and blink_mask are copied into the snapshot.
  - Same edge: frame_tick registers high for exactly one cycle.
  - Inputs are sampled only at this edge; changes mid-frame are invisible until the next frame.
- Registered outputs; all follow the registered index and slot counter with zero added latency.
  - an[idx] is active while slot counter >= GUARD_CYCLES; all other anodes are inactive.
  - During the guard window all anodes are inactive.
  - seg and dp hold the decode of the current digit for the whole slot.
- Decode (active-high, before inversion): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Codes 10..15 show "-" (40).
- Leading-zero blanking, when blank_lz=1:
  - Digit k is blanked if it and every higher digit in the snapshot are zero.
  - Digit 0 is never blanked.
  - A blanked digit gives seg off, and its anode still follows normal timing.
- Blink:
  - Blink counter increments on each frame boundary. At BLINK_FRAMES-1 it wraps to 0 and blink phase toggles.
  - When phase = 1, digits with the snapshot blink bit set show seg off and dp off.
- dp = snapshot dp bit for the current digit, unless that digit is blinked off. Leading-zero blanking does not suppress dp.
- First frame after reset displays the reset snapshot (zeros). New inputs appear from the second frame.
- Reset mid-slot: outputs go inactive immediately; scan restarts at digit 0, counter 0, after release.
- NUM_DIGITS and REFRESH_DIV are not powers of two in general; wrap is by explicit compare, never by overflow.

Decomposition:
- Shared clock package holds:
  - the 7-bit segment constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF);
  - the BCD digit width constant (4).
- One natural sub-module: bcd_to_7seg, a combinational decoder with a digit input and a 7-bit active-high output.
- Polarity inversion, blanking and blink logic stay in the top module.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, BLINK_FRAMES=2, both polarities active-low):
- Reset held, then released → an=1111, seg=7F, dp=1 during reset. First frame shows only digit 0 as 0 (seg=40) when blank_lz=1. frame_tick high once, 16 cycles after release.
- digits=16'h1234, blank_lz=0, after first frame_tick → per slot: an=1110 seg=19 (4), an=1101 seg=30 (3), an=1011 seg=24 (2), an=0111 seg=79 (1). First cycle of every slot has an=1111.
- digits=16'h0050, blank_lz=1 → digit 3 and digit 2 blanked (seg=7F), digit 1 shows 5 (seg=12), digit 0 shows 0 (seg=40). With dp_mask=4'b0100, dp=0 during slot 2 despite blanking.
- Change digits from 16'h0009 to 16'h0010 mid-frame → the current frame still shows 0009 in every slot. The next frame shows 0010. No frame mixes both values.
- blink_mask=4'b0011, digits=16'h1259 → digits 0 and 1 visible for 2 frames, then off (seg=7F, dp=1) for 2 frames, repeating. Digits 2 and 3 are unaffected.
- digits=16'h00A0 → digit 1 shows seg=3F ("-" inverted). Assert reset mid-slot 2 → an=1111 in the same cycle, without a clk edge.
